// File: rtl/result_drain_streamer.sv
// Reads result rows from the output BRAM bank array and serializes each row, lane 0 first, as a valid/ready word stream.
// Per row: 2 overhead cycles (address, capture), then one word per handshake; outputs are registered and hold under backpressure.
module result_drain_streamer #(
  parameter int DW        = 16,
  parameter int NUM_BRAMS = 16,
  parameter int O_ADDR_W  = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [O_ADDR_W-1:0]           base_addr,
  input  logic [O_ADDR_W:0]             num_rows,
  output logic                          busy,
  output logic                          done,
  output logic                          ext_read_mode,
  output logic [NUM_BRAMS*O_ADDR_W-1:0] ext_read_addr_flat,
  input  logic [NUM_BRAMS*DW-1:0]       ext_read_data_flat,
  output logic [DW-1:0]                 m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast
);

  localparam int LW = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_STR, S_DONE} state_t;

  state_t                  state_q;
  logic [O_ADDR_W-1:0]     base_q;
  logic [O_ADDR_W:0]       nrows_q;
  logic [O_ADDR_W:0]       row_q;
  logic [LW-1:0]           lane_q;
  logic [NUM_BRAMS*DW-1:0] rowbuf_q;
  logic [O_ADDR_W-1:0]     addr_q;
  logic                    busy_q, done_q, mode_q, tvalid_q, tlast_q;
  logic [DW-1:0]           tdata_q;

  logic [O_ADDR_W:0] row_d;
  logic [LW-1:0]     lane_d;
  logic              last_lane, last_row, hs;

  assign row_d     = row_q + (O_ADDR_W+1)'(1);
  assign lane_d    = lane_q + LW'(1);
  assign last_lane = (lane_q == LW'(NUM_BRAMS-1));
  assign last_row  = (row_q == nrows_q - (O_ADDR_W+1)'(1));
  assign hs        = tvalid_q & m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      nrows_q  <= '0;
      row_q    <= '0;
      lane_q   <= '0;
      rowbuf_q <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (num_rows != '0) begin
              base_q  <= base_addr;
              nrows_q <= num_rows;
              row_q   <= '0;
              addr_q  <= base_addr;
              mode_q  <= 1'b1;
              state_q <= S_RD;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        // Banks clock the address at the end of this cycle; data appears in CAP.
        S_RD: state_q <= S_CAP;
        S_CAP: begin
          rowbuf_q <= ext_read_data_flat;
          lane_q   <= '0;
          tdata_q  <= ext_read_data_flat[DW-1:0];
          tvalid_q <= 1'b1;
          tlast_q  <= (NUM_BRAMS == 1) && last_row;
          state_q  <= S_STR;
        end
        S_STR: begin
          if (hs) begin
            if (!last_lane) begin
              lane_q  <= lane_d;
              tdata_q <= rowbuf_q[lane_d*DW +: DW];
              tlast_q <= (lane_d == LW'(NUM_BRAMS-1)) && last_row;
            end else begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              if (last_row) begin
                mode_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                row_q   <= row_d;
                addr_q  <= base_q + row_d[O_ADDR_W-1:0];
                state_q <= S_RD;
              end
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign ext_read_mode      = mode_q;
  assign ext_read_addr_flat = {NUM_BRAMS{addr_q}};
  assign m_tdata            = tdata_q;
  assign m_tvalid           = tvalid_q;
  assign m_tlast            = tlast_q;

endmodule

// File: tb/tb_result_drain_streamer.sv
// Randomized bench for result_drain_streamer against a queue-based model of the drained word sequence.
module tb_result_drain_streamer;
  localparam int DW = 16, NB = 16, AW = 9, DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0, start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW:0]       num_rows = '0;
  logic              busy, done, ext_read_mode, m_tvalid, m_tlast;
  logic [NB*AW-1:0]  ext_read_addr_flat;
  logic [NB*DW-1:0]  rdata_q = '0;
  logic [DW-1:0]     m_tdata;
  logic              m_tready = 1'b1;

  result_drain_streamer #(.DW(DW), .NUM_BRAMS(NB), .O_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .ext_read_mode(ext_read_mode),
    .ext_read_addr_flat(ext_read_addr_flat), .ext_read_data_flat(rdata_q),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  // Bank array: one-cycle synchronous read, each lane uses its own address slice.
  logic [DW-1:0] mem [NB][DEPTH];
  always @(posedge clk)
    for (int k = 0; k < NB; k++) rdata_q[k*DW +: DW] <= mem[k][ext_read_addr_flat[k*AW +: AW]];

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { logic [DW-1:0] d; logic l; } word_t;
  word_t exp_q[$];
  word_t w;
  int    exp_addr[$], got_addr[$];
  int    words = 0, cur_cyc = 0, first_vld = -1;
  bit    saw_mode = 0;
  logic  prev_stall = 0, prev_last = 0, prev_mode = 0;
  logic [DW-1:0] prev_dat = '0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      prev_mode  = 0;
    end else begin
      if (ext_read_mode) saw_mode = 1;
      if (m_tvalid && first_vld < 0) first_vld = cur_cyc;
      if (prev_stall) begin
        chk("hold_vld", m_tvalid, 1);
        chk("hold_dat", m_tdata, prev_dat);
        chk("hold_last", m_tlast, prev_last);
      end
      if (m_tvalid) chk("vld_in_read_mode", ext_read_mode, 1);
      if (done) chk("done_vs_stream", {m_tvalid, m_tlast}, 0);
      if (ext_read_mode && (!prev_mode || ext_read_addr_flat[AW-1:0] != prev_addr)) begin
        got_addr.push_back(int'(ext_read_addr_flat[AW-1:0]));
        for (int k = 1; k < NB; k++)
          chk("addr_repl", ext_read_addr_flat[k*AW +: AW], ext_read_addr_flat[AW-1:0]);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("tdata", m_tdata, w.d);
          chk("tlast", m_tlast, w.l);
        end
        words++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_dat   = m_tdata;
      prev_last  = m_tlast;
      prev_mode  = ext_read_mode;
      prev_addr  = ext_read_addr_flat[AW-1:0];
    end
  end

  // 0: always ready, 1: 1,0,0,1 pattern, 2: random, 3: stall at word 39 (row 2 lane 7).
  int ready_mode = 0, rc = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_tready = 1'b1;
      1: begin m_tready = (rc % 4 == 0) || (rc % 4 == 3); rc++; end
      2: m_tready = 1'($urandom_range(0, 1));
      default: m_tready = (words < 39);
    endcase
  end

  task automatic build_model(input int base, input int n);
    int a;
    exp_q.delete(); exp_addr.delete(); got_addr.delete();
    words = 0; saw_mode = 0; rc = 0; first_vld = -1;
    for (int r = 0; r < n; r++) begin
      a = (base + r) % DEPTH;
      exp_addr.push_back(a);
      for (int k = 0; k < NB; k++) exp_q.push_back('{mem[k][a], (r == n-1) && (k == NB-1)});
    end
  endtask

  task automatic pulse_start(input int base, input int n);
    @(posedge clk); #1;
    start = 1; base_addr = AW'(base); num_rows = (AW+1)'(n);
    @(posedge clk); #1;
    start = 0; base_addr = AW'($urandom); num_rows = (AW+1)'($urandom_range(1, DEPTH));
    cur_cyc = 1;
  endtask

  task automatic run_drain(input int base, input int n, input int rmode, input bit midstart);
    int done_cyc = -1, na;
    build_model(base, n);
    ready_mode = rmode;
    pulse_start(base, n);
    while (done_cyc < 0 && cur_cyc < 20000) begin
      @(negedge clk);
      if (done) begin done_cyc = cur_cyc; chk("busy_at_done", busy, 1); end
      @(posedge clk); #1;
      start = midstart && (cur_cyc == 9);
      cur_cyc++;
    end
    start = 0;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    else begin
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
    end
    chk("word_count", words, NB * n);
    chk("words_left", exp_q.size(), 0);
    chk("row_count", got_addr.size(), exp_addr.size());
    na = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < na; i++) chk("row_addr", got_addr[i], exp_addr[i]);
    if (rmode == 0) chk("done_cycle", done_cyc, n * (NB + 2) + 1);
    if (n > 0) chk("first_vld_cycle", first_vld, 3);
    else chk("no_read_mode", saw_mode, 0);
  endtask

  task automatic check_outputs_clear(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mode"}, ext_read_mode, 0);
    chk({tag, "_vld"}, m_tvalid, 0);
    chk({tag, "_last"}, m_tlast, 0);
    chk({tag, "_dat"}, m_tdata, 0);
    chk({tag, "_addr"}, |ext_read_addr_flat, 0);
  endtask

  task automatic reset_midstream();
    int base = $urandom_range(0, DEPTH-1);
    int t = 0;
    build_model(base, 3);
    ready_mode = 3;
    pulse_start(base, 3);
    while (!(words == 39 && m_tvalid) && t < 500) begin @(negedge clk); t++; end
    chk("reached_stall", words, 39);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 0;
    #1 check_outputs_clear("rst_mid");
    repeat (3) @(negedge clk);
    rst_n = 1;
    run_drain($urandom_range(0, DEPTH-1), 1, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < NB; k++)
      for (int a = 0; a < DEPTH; a++) mem[k][a] = DW'($urandom);
    for (int k = 0; k < NB; k++) mem[k][5] = DW'(16'h0100 + k);

    repeat (2) @(negedge clk);
    check_outputs_clear("reset");
    rst_n = 1;

    run_drain(5, 1, 0, 0);
    run_drain(5, 1, 1, 0);
    run_drain(510, 4, 0, 0);
    run_drain(510, 4, 2, 0);
    run_drain($urandom_range(0, DEPTH-1), 0, 0, 0);
    run_drain(100, 3, 0, 1);
    run_drain(300, DEPTH, 0, 0);
    for (int i = 0; i < 6; i++)
      run_drain($urandom_range(0, DEPTH-1), $urandom_range(1, 6), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    reset_midstream();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/result_drain_streamer.md
# result_drain_streamer

Drains the output/accumulation BRAM bank array after a transpose-convolution pass. It takes ownership of the array's external result-read interface by driving the read-mode select and one row address to all banks. It captures the NUM_BRAMS-lane read row and serializes it as a valid/ready stream of DW-bit words toward the host DMA path. It is the consumer-side counterpart of the accumulation storage's external read port.

## Interface
- DW, 16, data width of one lane / one stream word
- NUM_BRAMS, 16, number of output banks (lanes per row)
- O_ADDR_W, 9, output BRAM address width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a drain; sampled only in IDLE
- base_addr  in  O_ADDR_W  first row address; sampled with start
- num_rows  in  O_ADDR_W+1  rows to drain, 0..2^O_ADDR_W; sampled with start
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle pulse when the drain completes
- ext_read_mode  out  1  drives the array's external read-mode select
- ext_read_addr_flat  out  NUM_BRAMS*O_ADDR_W  same row address replicated into every lane slice
- ext_read_data_flat  in  NUM_BRAMS*DW  bank read data, lane k at [k*DW +: DW]
- m_tdata  out  DW  stream word
- m_tvalid  out  1  stream word valid
- m_tready  in  1  downstream accept
- m_tlast  out  1  high on the final word of the whole drain

## Operation
- States: IDLE, RD, CAP, STR, DONE.
- IDLE: outputs are idle.
  - start=1 and num_rows≠0: latch base_addr, load row counter = 0, go to RD.
  - start=1 and num_rows=0: go directly to DONE; no read and no stream words.
- RD: ext_read_mode=1. Row address register = (base_addr + row) mod 2^O_ADDR_W, so addresses wrap. Go to CAP.
- CAP: ext_read_mode=1, address held. At the end of the cycle, capture ext_read_data_flat into a NUM_BRAMS*DW row buffer, clear lane counter, go to STR.
- STR: m_tvalid=1, m_tdata = row_buffer lane[lane counter]. Lane 0 goes first.
  - On handshake (m_tvalid&m_tready), increment the lane counter.
  - On handshake with lane=NUM_BRAMS-1: if row=num_rows-1, go to DONE; else increment row and go to RD.
- DONE: done=1 and busy=1 for exactly this cycle; ext_read_mode=0; go to IDLE.
- m_tlast = (state==STR) & (lane==NUM_BRAMS-1) & (row==num_rows_latched-1).
- start outside IDLE is ignored, and its parameters are not sampled.
- ext_read_mode stays 1 continuously from RD of the first row through STR of the last row, including STR cycles.
- The address only changes in RD.

## Timing
- Reset (asynchronous, any state): state=IDLE; busy, done, ext_read_mode, m_tvalid, m_tlast=0; m_tdata=0; ext_read_addr_flat=0; all counters and the row buffer = 0.
- Release of rst_n takes effect at the next rising edge. No partial drain resumes.
- The bank array has 1-cycle synchronous read latency: an address registered in RD is clocked by the banks at the RD→CAP edge, and data is valid during CAP.
- start sampled at edge 0 → RD during cycle 1 → CAP during cycle 2 → first m_tvalid during cycle 3.
- Each row costs 2 overhead cycles (RD, CAP) plus NUM_BRAMS handshakes.
- With m_tready held at 1, a drain takes num_rows*(NUM_BRAMS+2) cycles in RD/CAP/STR, plus 1 DONE cycle.
- Stream rule: once m_tvalid=1, m_tdata, m_tvalid and m_tlast hold stable until handshake. m_tvalid never drops without a handshake, except on reset.
- m_tvalid=0 in every state other than STR. m_tvalid does not depend combinationally on m_tready.
- done and m_tlast never overlap: done follows the last handshake by one cycle.
- num_rows=2^O_ADDR_W drains every address once, starting at base_addr and wrapping.

## Test plan
- Single row: preload row 5 lanes k = 0x0100+k; start with base_addr=5, num_rows=1, m_tready=1 → addr 5 replicated in all lanes; words 0x0100..0x010F on cycles 3..18; m_tlast only on 0x010F; done at cycle 19; busy low at cycle 20.
- Backpressure: same setup with m_tready toggling 1,0,0,1 → exactly 16 words in order; data held across stalls; no duplicates or drops; m_tvalid never deasserts while stalled.
- Wrap-around: base_addr=510, num_rows=4 → ext_read_addr sequence 510, 511, 0, 1; 64 words; m_tlast on word 63 only.
- Zero length and ignored start: num_rows=0 → done one cycle after start, no m_tvalid, ext_read_mode stays 0. A second start pulsed mid-drain → no effect on count or addresses.
- Reset mid-stream: assert rst_n low during row 2 lane 7 stalled → all outputs 0 immediately. A later fresh start with num_rows=1 streams correctly from lane 0.
